// File: rtl/cpu_intr_ctrl_pkg.sv
// Shared types for the CPU interrupt controller: FSM states and the trap payload.
package cpu_intr_ctrl_pkg;

  localparam int unsigned INTR_VEC_STRIDE = 4;
  localparam int unsigned INTR_CAUSE_W    = 4;

  typedef enum logic [1:0] {
    INTR_IDLE,
    INTR_TAKE,
    INTR_SERVICE
  } INTR_STATE;

  typedef struct packed {
    logic                    take;
    logic [31:0]             vec;
    logic [31:0]             epc;
    logic [INTR_CAUSE_W-1:0] cause;
  } INTR_TRAP;

endpackage

// File: rtl/cpu_intr_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending requests.
module intr_prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/cpu_intr_ctrl.sv
// Multi-channel interrupt controller: edge/level request latching, mask register,
// lowest-index selection and a one-cycle trap issued at an instruction boundary.
module cpu_intr_ctrl
  import cpu_intr_ctrl_pkg::*;
#(
  parameter int unsigned     NCH        = 4,
  parameter logic [NCH-1:0]  EDGE_MASK  = {{(NCH-1){1'b0}}, 1'b1},
  parameter logic [NCH-1:0]  RESET_MASK = {NCH{1'b1}},
  parameter logic [31:0]     VEC_BASE   = 32'h0000_0100,
  localparam int unsigned    CW         = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] irq_i,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_wdata,
  input  logic           intr_en_i,
  input  logic           commit_i,
  input  logic [31:0]    next_pc_i,
  input  logic           ret_i,
  output logic           irr_o,
  output logic [NCH-1:0] pend_o,
  output logic [NCH-1:0] mask_o,
  output logic           take_o,
  output logic [31:0]    vec_o,
  output logic [31:0]    epc_o,
  output logic [CW-1:0]  cause_o,
  output logic           busy_o
);

  INTR_STATE      state_q, state_d;
  INTR_TRAP       trap_q, trap_d;
  logic [NCH-1:0] irq_q, pend_q, pend_d, mask_q;
  logic [NCH-1:0] req, set_edge, claim;
  logic           sel_valid;
  logic [CW-1:0]  sel_idx;

  assign req = pend_q & mask_q;

  intr_prio_enc #(.N(NCH), .IW(CW)) u_prio (
    .req_i   (req),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  // Edge channels are sticky until claimed; a fresh edge beats a same-cycle claim.
  assign set_edge = irq_i & ~irq_q;
  assign pend_d   = (EDGE_MASK & (set_edge | (pend_q & ~claim))) | (~EDGE_MASK & irq_i);

  // Trap sequencing and claim generation.
  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    trap_d.take = 1'b0;
    claim      = '0;
    case (state_q)
      INTR_IDLE: begin
        if (commit_i && intr_en_i && sel_valid) begin
          state_d        = INTR_TAKE;
          trap_d.take    = 1'b1;
          trap_d.vec     = VEC_BASE + 32'(sel_idx) * 32'(INTR_VEC_STRIDE);
          trap_d.epc     = next_pc_i;
          trap_d.cause   = INTR_CAUSE_W'(sel_idx);
          claim[sel_idx] = 1'b1;
        end
      end
      INTR_TAKE:    state_d = INTR_SERVICE;
      INTR_SERVICE: if (ret_i) state_d = INTR_IDLE;
      default:      state_d = INTR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INTR_IDLE;
      trap_q  <= '0;
      irq_q   <= '0;
      pend_q  <= '0;
      mask_q  <= RESET_MASK;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      irq_q   <= irq_i;
      pend_q  <= pend_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign irr_o   = |req;
  assign pend_o  = pend_q;
  assign mask_o  = mask_q;
  assign take_o  = trap_q.take;
  assign vec_o   = trap_q.vec;
  assign epc_o   = trap_q.epc;
  assign cause_o = CW'(trap_q.cause);
  assign busy_o  = (state_q != INTR_IDLE);

endmodule

// File: tb/tb_cpu_intr_ctrl.sv
// Scoreboard bench for cpu_intr_ctrl: directed scenarios then randomized traffic
// against a cycle-level behavioural model of the interrupt rules.
module tb_cpu_intr_ctrl;

  localparam int unsigned    NCH   = 4;
  localparam logic [NCH-1:0] EDGE_M = 4'b0001;
  localparam logic [NCH-1:0] RST_M  = 4'b1111;
  localparam logic [31:0]    VBASE  = 32'h0000_0100;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] irq_i, mask_wdata, pend_o, mask_o;
  logic           mask_we, intr_en_i, commit_i, ret_i;
  logic [31:0]    next_pc_i, vec_o, epc_o;
  logic           irr_o, take_o, busy_o;
  logic [1:0]     cause_o;

  always #5 clk = ~clk;

  cpu_intr_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq_i      (irq_i),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .intr_en_i  (intr_en_i),
    .commit_i   (commit_i),
    .next_pc_i  (next_pc_i),
    .ret_i      (ret_i),
    .irr_o      (irr_o),
    .pend_o     (pend_o),
    .mask_o     (mask_o),
    .take_o     (take_o),
    .vec_o      (vec_o),
    .epc_o      (epc_o),
    .cause_o    (cause_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    logic [31:0] vec;
    logic [31:0] epc;
    int          cause;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   run    = 0;

  // Model: pending bits, last-seen request lines, mask, and whether a trap is outstanding.
  bit          m_pend [NCH];
  bit          m_prev [NCH];
  bit          m_mask [NCH];
  bit          m_trap;
  bit          m_take;
  logic [31:0] m_epc;
  int          m_cause;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NCH-1:0] pack_bits(input bit a [NCH]);
    logic [NCH-1:0] v;
    for (int i = 0; i < int'(NCH); i++) v[i] = a[i];
    return v;
  endfunction

  function automatic bit any_enabled();
    bit r = 0;
    for (int i = 0; i < int'(NCH); i++) if (m_pend[i] && m_mask[i]) r = 1;
    return r;
  endfunction

  task automatic model_reset();
    logic [NCH-1:0] rm = RST_M;
    for (int i = 0; i < int'(NCH); i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
      m_mask[i] = rm[i];
    end
    m_trap  = 0;
    m_take  = 0;
    m_epc   = '0;
    m_cause = 0;
  endtask

  // Advance the model by one clock given this cycle's inputs; predicted traps go to the queue.
  task automatic model_step(input bit rst, input logic [NCH-1:0] irq, input bit we,
                            input logic [NCH-1:0] wd, input bit en, input bit cm,
                            input logic [31:0] pc, input bit rt);
    logic [NCH-1:0] em = EDGE_M;
    int claim = -1;
    bit nt    = m_take;
    bit ntrap = m_trap;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_take) nt = 0;
    else if (m_trap) begin
      if (rt) ntrap = 0;
    end else if (cm && en) begin
      for (int i = 0; i < int'(NCH); i++) if (claim < 0 && m_pend[i] && m_mask[i]) claim = i;
      if (claim >= 0) begin
        nt      = 1;
        ntrap   = 1;
        m_epc   = pc;
        m_cause = claim;
        q.push_back('{vec: VBASE + 32'(4 * claim), epc: pc, cause: claim, due: cyc + 1});
      end
    end
    for (int i = 0; i < int'(NCH); i++) begin
      if (em[i]) m_pend[i] = (irq[i] && !m_prev[i]) || (m_pend[i] && i != claim);
      else       m_pend[i] = irq[i];
      m_prev[i] = irq[i];
      if (we) m_mask[i] = wd[i];
    end
    m_take = nt;
    m_trap = ntrap;
  endtask

  // One clock: check registered outputs against the model, drive inputs, advance the model.
  task automatic cycle(input bit rst, input logic [NCH-1:0] irq, input bit we,
                       input logic [NCH-1:0] wd, input bit en, input bit cm,
                       input logic [31:0] pc, input bit rt);
    @(negedge clk);
    chk("pend", 32'(pend_o), 32'(pack_bits(m_pend)));
    chk("mask", 32'(mask_o), 32'(pack_bits(m_mask)));
    chk("irr", 32'(irr_o), 32'(any_enabled()));
    chk("busy", 32'(busy_o), 32'(m_trap));
    if (m_trap) begin
      chk("epc_hold", epc_o, m_epc);
      chk("cause_hold", 32'(cause_o), 32'(m_cause));
    end
    reset      = rst;
    irq_i      = irq;
    mask_we    = we;
    mask_wdata = wd;
    intr_en_i  = en;
    commit_i   = cm;
    next_pc_i  = pc;
    ret_i      = rt;
    model_step(rst, irq, we, wd, en, cm, pc, rt);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every trap pulse must match the oldest prediction, on the predicted cycle.
  always @(negedge clk) begin
    if (run) begin
      if (take_o) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL take_unexpected cycle %0d: got take_o=1 expected no trap", cyc);
        end else begin
          e = q.pop_front();
          chk("take_cycle", 32'(cyc), 32'(e.due));
          chk("vec", vec_o, e.vec);
          chk("epc", epc_o, e.epc);
          chk("cause", 32'(cause_o), 32'(e.cause));
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        checks++;
        fails++;
        $display("FAIL take_missing cycle %0d: got take_o=0 expected trap due at %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; irq_i = '0; mask_we = 1'b0; mask_wdata = '0;
    intr_en_i = 1'b0; commit_i = 1'b0; next_pc_i = '0; ret_i = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    run = 1;
    @(negedge clk);
    chk("rst_take", 32'(take_o), 32'd0);
    chk("rst_vec", vec_o, 32'd0);
    chk("rst_epc", epc_o, 32'd0);
    chk("rst_cause", 32'(cause_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_mask", 32'(mask_o), 32'hF);

    // Edge ch0 pulse, trap two cycles later.
    cycle(0, 4'b0001, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b0000, 0, 4'h0, 1, 1, 32'h40, 0);
    after_edge();
    chk("t1_take", 32'(take_o), 32'd1);
    chk("t1_vec", vec_o, 32'h100);
    chk("t1_epc", epc_o, 32'h40);
    chk("t1_pend0", 32'(pend_o[0]), 32'd0);
    cycle(0, 4'b0000, 0, 4'h0, 1, 1, 32'h0, 1);
    cycle(0, 4'b0000, 0, 4'h0, 1, 1, 32'h0, 1);
    after_edge();
    chk("t1_idle", 32'(busy_o), 32'd0);

    // Levels ch1+ch3: lowest wins, then ch3 after ch1 drops.
    cycle(0, 4'b1010, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b1010, 0, 4'h0, 1, 1, 32'h200, 0);
    after_edge();
    chk("t2_vec1", vec_o, 32'h104);
    chk("t2_cause1", 32'(cause_o), 32'd1);
    cycle(0, 4'b1000, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b1000, 0, 4'h0, 1, 0, 32'h0, 1);
    cycle(0, 4'b1000, 0, 4'h0, 1, 1, 32'h204, 0);
    after_edge();
    chk("t2_vec3", vec_o, 32'h10C);
    chk("t2_cause3", 32'(cause_o), 32'd3);
    cycle(0, 4'b0000, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b0000, 0, 4'h0, 1, 0, 32'h0, 1);

    // Masked ch2, then unmask; the unmasking cycle still selects with the old mask.
    cycle(0, 4'b0100, 1, 4'b1011, 1, 0, 32'h0, 0);
    cycle(0, 4'b0100, 0, 4'h0, 1, 1, 32'h0, 0);
    after_edge();
    chk("t3_irr", 32'(irr_o), 32'd0);
    chk("t3_busy", 32'(busy_o), 32'd0);
    cycle(0, 4'b0100, 1, 4'b1111, 1, 1, 32'h0, 0);
    cycle(0, 4'b0100, 0, 4'h0, 1, 1, 32'h80, 0);
    after_edge();
    chk("t3_cause", 32'(cause_o), 32'd2);
    cycle(0, 4'b0000, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b0000, 0, 4'h0, 1, 0, 32'h0, 1);

    // Ch0 re-pulse in the claim cycle keeps it pending for a second trap.
    cycle(0, 4'b0001, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b0000, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b0001, 0, 4'h0, 1, 1, 32'h300, 0);
    after_edge();
    chk("t4_take", 32'(take_o), 32'd1);
    chk("t4_pend", 32'(pend_o), 32'b0001);
    cycle(0, 4'b0000, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b0000, 0, 4'h0, 1, 0, 32'h0, 1);
    cycle(0, 4'b0000, 0, 4'h0, 1, 1, 32'h304, 0);
    after_edge();
    chk("t4_second", 32'(take_o), 32'd1);
    cycle(0, 4'b0000, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b0000, 0, 4'h0, 1, 0, 32'h0, 1);

    // Reset while in SERVICE with everything pending.
    cycle(0, 4'b0001, 0, 4'h0, 1, 0, 32'h0, 0);
    cycle(0, 4'b1110, 0, 4'h0, 1, 1, 32'hC0, 0);
    cycle(0, 4'b1111, 1, 4'b1011, 1, 0, 32'h0, 0);
    cycle(0, 4'b1111, 0, 4'h0, 1, 0, 32'h0, 0);
    after_edge();
    chk("t6_pend_full", 32'(pend_o), 32'hF);
    cycle(1, 4'b1111, 0, 4'h0, 1, 0, 32'h0, 0);
    after_edge();
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_pend", 32'(pend_o), 32'd0);
    chk("t6_mask", 32'(mask_o), 32'hF);
    chk("t6_take", 32'(take_o), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 299) == 0, 4'($urandom), $urandom_range(0, 19) == 0,
            4'($urandom), $urandom_range(0, 99) < 85, $urandom_range(0, 1) == 1,
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4) == 0);
    end
    for (int n = 0; n < 6; n++) cycle(0, 4'b0000, 0, 4'h0, 0, 0, 32'h0, 1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
